// File: rtl/hvac_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : hvac_scheduler
// Purpose  : Heater/cooler scheduler with hysteresis, minimum run time, a rest
//            period between activations and fire-alarm inhibit.
// Option   : HVAC_LOCKOUT_EN - REST lasts MIN_OFF cycles and drives lockout;
//            when undefined REST lasts one cycle and lockout is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module hvac_scheduler #(
    parameter int LOW_TH  = 50,
    parameter int HIGH_TH = 80,
    parameter int HYST    = 2,
    parameter int MIN_RUN = 16,
    parameter int MIN_OFF = 8,
    parameter int CNT_W   = 8
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [6:0] ST,
    input  logic       SFA,
    output logic       heater,
    output logic       cooler,
    output logic [1:0] hvac_state,
    output logic       lockout
);

    localparam logic [1:0] c_st_idle = 2'b00;
    localparam logic [1:0] c_st_heat = 2'b01;
    localparam logic [1:0] c_st_cool = 2'b10;
    localparam logic [1:0] c_st_rest = 2'b11;

    // Thresholds are held at 8 bits so LOW_TH+HYST cannot wrap against a 7-bit input
    localparam logic [7:0] c_low_th    = 8'(LOW_TH);
    localparam logic [7:0] c_high_th   = 8'(HIGH_TH);
    localparam logic [7:0] c_heat_exit = 8'(LOW_TH + HYST);
    localparam logic [7:0] c_cool_exit = 8'(HIGH_TH - HYST);

    localparam logic [CNT_W-1:0] c_cnt_max  = '1;
    localparam logic [CNT_W-1:0] c_run_last = CNT_W'(MIN_RUN - 1);
`ifdef HVAC_LOCKOUT_EN
    localparam logic [CNT_W-1:0] c_rest_last = CNT_W'(MIN_OFF - 1);
`else
    // Counter is zero on REST entry, so REST always ends after one cycle
    localparam logic [CNT_W-1:0] c_rest_last = '0;
`endif

    if (MIN_RUN < 1 || MIN_RUN > (2 ** CNT_W) - 1) begin : g_chk_min_run
        $error("hvac_scheduler: MIN_RUN out of range");
    end
    if (MIN_OFF < 1 || MIN_OFF > (2 ** CNT_W) - 1) begin : g_chk_min_off
        $error("hvac_scheduler: MIN_OFF out of range");
    end

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_heater;
    logic             r_cooler;

    logic [1:0]       w_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic [7:0]       w_st;
    logic             w_run_done;

    assign w_st       = {1'b0, ST};
    assign w_run_done = (r_cnt >= c_run_last);

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (!SFA) begin
                    if (w_st < c_low_th) begin
                        w_next = c_st_heat;
                    end else if (w_st > c_high_th) begin
                        w_next = c_st_cool;
                    end
                end
            end
            c_st_heat: begin
                if (SFA || (w_st >= c_heat_exit && w_run_done)) begin
                    w_next = c_st_rest;
                end
            end
            c_st_cool: begin
                if (SFA || (w_st <= c_cool_exit && w_run_done)) begin
                    w_next = c_st_rest;
                end
            end
            c_st_rest: begin
                if (r_cnt == c_rest_last) begin
                    w_next = c_st_idle;
                end
            end
            default: w_next = c_st_idle;
        endcase
    end

    // Cleared on every state entry, saturating while the state holds
    always_comb begin
        w_cnt_next = '0;
        if (w_next == r_state) begin
            w_cnt_next = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + CNT_W'(1);
        end
    end

    // Outputs are decoded from the next state so they change on the same edge
    always_ff @(negedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state  <= c_st_idle;
            r_cnt    <= '0;
            r_heater <= 1'b0;
            r_cooler <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_cnt    <= w_cnt_next;
            r_heater <= (w_next == c_st_heat);
            r_cooler <= (w_next == c_st_cool);
        end
    end

`ifdef HVAC_LOCKOUT_EN
    logic r_lockout;

    always_ff @(negedge Clk or posedge Rst) begin
        if (Rst) begin
            r_lockout <= 1'b0;
        end else begin
            r_lockout <= (w_next == c_st_rest);
        end
    end

    assign lockout = r_lockout;
`else
    assign lockout = 1'b0;
`endif

    assign heater     = r_heater;
    assign cooler     = r_cooler;
    assign hvac_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_hvac_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_hvac_scheduler
// Purpose  : Directed self-checking bench for hvac_scheduler (default params).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hvac_scheduler;

`ifdef HVAC_LOCKOUT_EN
    localparam int   REST_LEN = 8;
    localparam logic LOCK_EXP = 1'b1;
`else
    localparam int   REST_LEN = 1;
    localparam logic LOCK_EXP = 1'b0;
`endif

    // {heater, cooler, hvac_state, lockout}
    localparam logic [4:0] E_IDLE = 5'b0_0_00_0;
    localparam logic [4:0] E_HEAT = 5'b1_0_01_0;
    localparam logic [4:0] E_COOL = 5'b0_1_10_0;
    localparam logic [4:0] E_REST = {4'b0_0_11, LOCK_EXP};

    logic       Clk = 1'b1;
    logic       Rst = 1'b0;
    logic [6:0] ST  = 7'd65;
    logic       SFA = 1'b0;
    logic       heater;
    logic       cooler;
    logic [1:0] hvac_state;
    logic       lockout;
    logic [4:0] obs;

    int n_vec = 0;
    int n_err = 0;

    hvac_scheduler dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .ST         (ST),
        .SFA        (SFA),
        .heater     (heater),
        .cooler     (cooler),
        .hvac_state (hvac_state),
        .lockout    (lockout)
    );

    always #5 Clk = ~Clk;

    assign obs = {heater, cooler, hvac_state, lockout};

    // DUT acts on the falling edge; the bench drives and samples on the rising edge
    task automatic cyc;
        @(negedge Clk);
        @(posedge Clk);
    endtask

    task automatic pulse_reset(input logic [6:0] st);
        ST  = st;
        SFA = 1'b0;
        Rst = 1'b1;
        #1;
        Rst = 1'b0;
    endtask

    task automatic test_reset;
        ST = 7'd20;
        #1 Rst = 1'b1;
        #1;
        n_vec++;
        if (obs !== E_IDLE) begin
            n_err++;
            $display("FAIL reset_async: got %b want %b", obs, E_IDLE);
        end
        @(posedge Clk);
        n_vec++;
        if (obs !== E_IDLE) begin
            n_err++;
            $display("FAIL reset_held: got %b want %b", obs, E_IDLE);
        end
        Rst = 1'b0;
        cyc();
        n_vec++;
        if (obs !== E_HEAT) begin
            n_err++;
            $display("FAIL reset_release: got %b want %b", obs, E_HEAT);
        end
    endtask

    task automatic test_min_run;
        pulse_reset(7'd40);
        for (int i = 1; i <= 16; i++) begin
            cyc();
            n_vec++;
            if (obs !== E_HEAT) begin
                n_err++;
                $display("FAIL min_run_heat cyc %0d: got %b want %b", i, obs, E_HEAT);
            end
            if (i == 3) ST = 7'd60;
        end
        for (int r = 1; r <= REST_LEN; r++) begin
            cyc();
            n_vec++;
            if (obs !== E_REST) begin
                n_err++;
                $display("FAIL min_run_rest cyc %0d: got %b want %b", r, obs, E_REST);
            end
        end
        cyc();
        n_vec++;
        if (obs !== E_IDLE) begin
            n_err++;
            $display("FAIL min_run_idle: got %b want %b", obs, E_IDLE);
        end
    endtask

    task automatic test_thresholds;
        pulse_reset(7'd50);
        cyc();
        n_vec++;
        if (obs !== E_IDLE) begin
            n_err++;
            $display("FAIL idle_at_low_th: got %b want %b", obs, E_IDLE);
        end
        ST = 7'd80;
        cyc();
        n_vec++;
        if (obs !== E_IDLE) begin
            n_err++;
            $display("FAIL idle_at_high_th: got %b want %b", obs, E_IDLE);
        end
        ST = 7'd81;
        cyc();
        n_vec++;
        if (obs !== E_COOL) begin
            n_err++;
            $display("FAIL cool_entry_81: got %b want %b", obs, E_COOL);
        end
        ST = 7'd79;
        for (int i = 2; i <= 20; i++) begin
            cyc();
            n_vec++;
            if (obs !== E_COOL) begin
                n_err++;
                $display("FAIL cool_hyst_79 cyc %0d: got %b want %b", i, obs, E_COOL);
            end
        end
        ST = 7'd78;
        cyc();
        n_vec++;
        if (obs !== E_REST) begin
            n_err++;
            $display("FAIL cool_hyst_78: got %b want %b", obs, E_REST);
        end
        pulse_reset(7'd49);
        cyc();
        n_vec++;
        if (obs !== E_HEAT) begin
            n_err++;
            $display("FAIL heat_entry_49: got %b want %b", obs, E_HEAT);
        end
    endtask

    task automatic test_hysteresis;
        pulse_reset(7'd40);
        for (int i = 1; i <= 20; i++) begin
            cyc();
            n_vec++;
            if (obs !== E_HEAT) begin
                n_err++;
                $display("FAIL hyst_run cyc %0d: got %b want %b", i, obs, E_HEAT);
            end
        end
        ST = 7'd51;
        cyc();
        n_vec++;
        if (obs !== E_HEAT) begin
            n_err++;
            $display("FAIL hyst_51: got %b want %b", obs, E_HEAT);
        end
        ST = 7'd52;
        cyc();
        n_vec++;
        if (obs !== E_REST) begin
            n_err++;
            $display("FAIL hyst_52: got %b want %b", obs, E_REST);
        end
    endtask

    task automatic test_fire;
        pulse_reset(7'd90);
        for (int i = 1; i <= 3; i++) begin
            cyc();
            n_vec++;
            if (obs !== E_COOL) begin
                n_err++;
                $display("FAIL fire_cool cyc %0d: got %b want %b", i, obs, E_COOL);
            end
        end
        SFA = 1'b1;
        for (int r = 1; r <= REST_LEN; r++) begin
            cyc();
            n_vec++;
            if (obs !== E_REST) begin
                n_err++;
                $display("FAIL fire_rest cyc %0d: got %b want %b", r, obs, E_REST);
            end
        end
        for (int k = 1; k <= 4; k++) begin
            cyc();
            n_vec++;
            if (obs !== E_IDLE) begin
                n_err++;
                $display("FAIL fire_hold cyc %0d: got %b want %b", k, obs, E_IDLE);
            end
        end
        SFA = 1'b0;
        cyc();
        n_vec++;
        if (obs !== E_COOL) begin
            n_err++;
            $display("FAIL fire_release: got %b want %b", obs, E_COOL);
        end
    endtask

    task automatic test_back_to_back;
        logic [4:0] exp;
        pulse_reset(7'd30);
        for (int i = 1; i <= REST_LEN + 18; i++) begin
            if (i == 17) ST = 7'd100;
            cyc();
            if (i <= 16)                 exp = E_HEAT;
            else if (i <= 16 + REST_LEN) exp = E_REST;
            else if (i == 17 + REST_LEN) exp = E_IDLE;
            else                         exp = E_COOL;
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL swap cyc %0d: got %b want %b", i, obs, exp);
            end
            n_vec++;
            if ((heater & cooler) !== 1'b0) begin
                n_err++;
                $display("FAIL swap_excl cyc %0d: heater %b cooler %b both required not high", i, heater, cooler);
            end
        end
    endtask

    task automatic test_reset_mid_rest;
        int m;
        m = (REST_LEN < 4) ? REST_LEN : 4;
        pulse_reset(7'd40);
        for (int i = 1; i <= 16; i++) cyc();
        ST = 7'd60;
        for (int r = 1; r <= m; r++) cyc();
        n_vec++;
        if (obs !== E_REST) begin
            n_err++;
            $display("FAIL midrest_before: got %b want %b", obs, E_REST);
        end
        Rst = 1'b1;
        #1;
        n_vec++;
        if (obs !== E_IDLE) begin
            n_err++;
            $display("FAIL midrest_async: got %b want %b", obs, E_IDLE);
        end
        #1;
        ST  = 7'd40;
        Rst = 1'b0;
        cyc();
        n_vec++;
        if (obs !== E_HEAT) begin
            n_err++;
            $display("FAIL midrest_restart: got %b want %b", obs, E_HEAT);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_min_run();
        test_thresholds();
        test_hysteresis();
        test_fire();
        test_back_to_back();
        test_reset_mid_rest();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
